// File: rtl/fmc_adc_trig_pkg.sv
// Shared definitions for the FMC-ADC internal and external trigger paths.
package fmc_adc_trig_pkg;

    // Comparison width; wide enough for any data width up to 32 bits plus sign.
    localparam int unsigned c_CMP_WIDTH = 33;

    localparam logic c_POL_RISING  = 1'b0;
    localparam logic c_POL_FALLING = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ARM,
        ST_ARMED,
        ST_QUALIFY,
        ST_DELAY
    } t_thres_trig_state;

    function automatic logic f_cmp_cross(
        input logic                          pol,
        input logic signed [c_CMP_WIDTH-1:0] data,
        input logic signed [c_CMP_WIDTH-1:0] thres
    );
        if (pol == c_POL_FALLING) begin
            return data <= thres;
        end
        return data >= thres;
    endfunction

endpackage

// File: rtl/fmc_adc_trig_dly.sv
// Loadable down-counter advanced by the sample strobe; done_c_o flags the last tick.
module fmc_adc_trig_dly #(
    parameter int unsigned g_DLY_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [g_DLY_WIDTH-1:0] load_val_i,
    input  logic                   tick_i,
    output logic                   done_c_o
);

    logic [g_DLY_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - g_DLY_WIDTH'(1);
        end
    end

    assign done_c_o = tick_i && !clr_i && !load_i && (cnt_q == g_DLY_WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fmc_adc_thres_trig.sv
// Per-channel threshold trigger: hysteresis arming, glitch filter and strobe-counted delay.
module fmc_adc_thres_trig
    import fmc_adc_trig_pkg::*;
#(
    parameter int unsigned g_DATA_WIDTH   = 16,
    parameter int unsigned g_GLITCH_WIDTH = 8,
    parameter int unsigned g_DLY_WIDTH    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic                      pol_i,
    input  logic [g_DATA_WIDTH-1:0]   thres_i,
    input  logic [g_DATA_WIDTH-1:0]   hyst_i,
    input  logic [g_GLITCH_WIDTH-1:0] glitch_len_i,
    input  logic [g_DLY_WIDTH-1:0]    dly_i,
    input  logic [g_DATA_WIDTH-1:0]   data_i,
    input  logic                      data_valid_i,
    output logic                      trig_o,
    output logic                      armed_o,
    output logic                      busy_o
);

    localparam int unsigned c_XW = g_DATA_WIDTH + 1;

    t_thres_trig_state         state_q, state_d;
    logic [g_GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic                      trig_q, trig_d;
    logic                      armed_q, armed_d;
    logic                      busy_q, busy_d;
    logic                      fire;
    logic                      dly_clr, dly_load, dly_done_c;

    // Sign-extended operands; one extra bit keeps thres -/+ hyst from wrapping.
    logic signed [c_XW-1:0] data_x, thres_x, hyst_x, lo_x, hi_x;
    logic                   arm_c, cross_c;

    assign data_x  = signed'({data_i[g_DATA_WIDTH-1], data_i});
    assign thres_x = signed'({thres_i[g_DATA_WIDTH-1], thres_i});
    assign hyst_x  = signed'({1'b0, hyst_i});
    assign lo_x    = thres_x - hyst_x;
    assign hi_x    = thres_x + hyst_x;

    assign arm_c   = (pol_i == c_POL_RISING) ? (data_x < lo_x) : (data_x > hi_x);
    assign cross_c = f_cmp_cross(pol_i, c_CMP_WIDTH'(data_x), c_CMP_WIDTH'(thres_x));

    fmc_adc_trig_dly #(
        .g_DLY_WIDTH (g_DLY_WIDTH)
    ) u_dly (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (dly_clr),
        .load_i     (dly_load),
        .load_val_i (dly_i),
        .tick_i     (data_valid_i),
        .done_c_o   (dly_done_c)
    );

    always_comb begin
        state_d  = state_q;
        glitch_d = glitch_q;
        trig_d   = 1'b0;
        fire     = 1'b0;
        dly_clr  = 1'b0;
        dly_load = 1'b0;

        if (!en_i) begin
            state_d  = ST_IDLE;
            glitch_d = '0;
            dly_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_ARM;
                ST_WAIT_ARM: begin
                    if (data_valid_i && arm_c) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (data_valid_i && cross_c) begin
                        if (glitch_len_i == '0) begin
                            fire = 1'b1;
                        end else begin
                            state_d  = ST_QUALIFY;
                            glitch_d = g_GLITCH_WIDTH'(1);
                        end
                    end
                end
                // glitch_q counts crossing samples seen so far in this run.
                ST_QUALIFY: begin
                    if (data_valid_i) begin
                        if (!cross_c) begin
                            state_d  = ST_ARMED;
                            glitch_d = '0;
                        end else if (glitch_q == glitch_len_i) begin
                            fire = 1'b1;
                        end else begin
                            glitch_d = glitch_q + g_GLITCH_WIDTH'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_done_c) begin
                        state_d = ST_WAIT_ARM;
                        trig_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (fire) begin
                glitch_d = '0;
                if (dly_i == '0) begin
                    state_d = ST_WAIT_ARM;
                    trig_d  = 1'b1;
                end else begin
                    state_d  = ST_DELAY;
                    dly_load = 1'b1;
                end
            end
        end

        armed_d = (state_d == ST_ARMED) || (state_d == ST_QUALIFY);
        busy_d  = (state_d == ST_DELAY);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            glitch_q <= '0;
            trig_q   <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            glitch_q <= glitch_d;
            trig_q   <= trig_d;
            armed_q  <= armed_d;
            busy_q   <= busy_d;
        end
    end

    assign trig_o  = trig_q;
    assign armed_o = armed_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_fmc_adc_thres_trig.sv
// Directed bench for fmc_adc_thres_trig with hand-computed expectations.
module tb_fmc_adc_thres_trig;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic        pol_i = 1'b0;
    logic [15:0] thres_i = '0;
    logic [15:0] hyst_i = '0;
    logic [7:0]  glitch_len_i = '0;
    logic [31:0] dly_i = '0;
    logic [15:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        trig_o, armed_o, busy_o;

    int n_vec = 0;
    int n_err = 0;
    int n_trig = 0;

    fmc_adc_thres_trig dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .pol_i        (pol_i),
        .thres_i      (thres_i),
        .hyst_i       (hyst_i),
        .glitch_len_i (glitch_len_i),
        .dly_i        (dly_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .trig_o       (trig_o),
        .armed_o      (armed_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (trig_o) n_trig++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One strobe; returns trig_o as seen just after the edge that consumed it.
    task automatic sample(input logic [15:0] d, output logic t);
        data_i       = d;
        data_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        t = trig_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic restart();
        en_i = 1'b0;
        idle(2);
        en_i = 1'b1;
        idle(1);
    endtask

    logic t;
    int   base;
    logic seen_armed;
    logic [15:0] sw;

    initial begin
        idle(2);
        chk("rst_trig", 32'(trig_o), 32'd0);
        chk("rst_armed", 32'(armed_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n_i = 1'b1;
        idle(1);

        // Rising threshold
        thres_i = 16'h0300; hyst_i = 16'h0100; glitch_len_i = 8'd0; dly_i = 32'd0; pol_i = 1'b0;
        restart();
        sample(16'h0100, t);
        chk("rise_arm_trig", 32'(t), 32'd0);
        chk("rise_armed", 32'(armed_o), 32'd1);
        base = n_trig;
        sample(16'h0310, t);
        chk("rise_cross_trig", 32'(t), 32'd1);
        chk("rise_disarm", 32'(armed_o), 32'd0);
        repeat (50) sample(16'h0310, t);
        chk("rise_hold_once", 32'(n_trig - base), 32'd1);

        // Hysteresis
        restart();
        sample(16'h0100, t);
        sample(16'h0310, t); chk("hys_t1", 32'(t), 32'd1);
        sample(16'h0250, t); chk("hys_250", 32'(t), 32'd0);
        chk("hys_not_armed", 32'(armed_o), 32'd0);
        sample(16'h0310, t); chk("hys_no_retrig", 32'(t), 32'd0);
        sample(16'h01F0, t); chk("hys_rearm", 32'(armed_o), 32'd1);
        sample(16'h0310, t); chk("hys_t2", 32'(t), 32'd1);

        // Glitch filter with sparse strobes
        glitch_len_i = 8'd2;
        restart();
        sample(16'h0100, t);
        sample(16'h0310, t); chk("gl_1", 32'(t), 32'd0);
        sample(16'h0310, t); chk("gl_2", 32'(t), 32'd0);
        sample(16'h0200, t); chk("gl_break", 32'(t), 32'd0);
        chk("gl_still_armed", 32'(armed_o), 32'd1);
        sample(16'h0310, t); chk("gl_r1", 32'(t), 32'd0);
        idle(3);
        sample(16'h0310, t); chk("gl_r2", 32'(t), 32'd0);
        idle(2);
        sample(16'h0310, t); chk("gl_r3", 32'(t), 32'd1);

        // Falling polarity with delay
        glitch_len_i = 8'd0; pol_i = 1'b1; thres_i = 16'h0000; hyst_i = 16'h0040; dly_i = 32'd3;
        restart();
        sample(16'h0050, t);
        chk("fall_armed", 32'(armed_o), 32'd1);
        base = n_trig;
        sample(16'hFFF0, t); chk("fall_q", 32'(t), 32'd0);
        chk("fall_busy0", 32'(busy_o), 32'd1);
        sample(16'hFFE0, t); chk("fall_d1", 32'(t), 32'd0);
        chk("fall_busy1", 32'(busy_o), 32'd1);
        idle(2);
        sample(16'hFFE0, t); chk("fall_d2", 32'(t), 32'd0);
        chk("fall_busy2", 32'(busy_o), 32'd1);
        sample(16'h0000, t); chk("fall_d3", 32'(t), 32'd1);
        chk("fall_busy_end", 32'(busy_o), 32'd0);
        sample(16'hFFF0, t); chk("fall_needs_arm", 32'(t), 32'd0);
        chk("fall_count", 32'(n_trig - base), 32'd1);

        // Disable mid-delay
        pol_i = 1'b0; thres_i = 16'h0300; hyst_i = 16'h0100; dly_i = 32'd100;
        restart();
        base = n_trig;
        sample(16'h0100, t);
        sample(16'h0310, t);
        repeat (10) sample(16'h0310, t);
        chk("dis_busy_pre", 32'(busy_o), 32'd1);
        en_i = 1'b0;
        idle(1);
        chk("dis_busy", 32'(busy_o), 32'd0);
        chk("dis_armed", 32'(armed_o), 32'd0);
        sample(16'h0100, t);
        chk("dis_idle", 32'(armed_o), 32'd0);
        repeat (100) sample(16'h0310, t);
        chk("dis_no_trig", 32'(n_trig - base), 32'd0);

        // Reset mid-delay
        restart();
        sample(16'h0100, t);
        sample(16'h0310, t);
        repeat (10) sample(16'h0310, t);
        chk("rst_busy_pre", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_trig", 32'(trig_o), 32'd0);
        chk("arst_armed", 32'(armed_o), 32'd0);
        idle(1);
        rst_n_i = 1'b1;
        repeat (100) sample(16'h0310, t);
        chk("arst_no_trig", 32'(n_trig - base), 32'd0);

        // Extremes: lo = -0xFFFF, never arms
        thres_i = 16'h8000; hyst_i = 16'h7FFF; dly_i = 32'd0;
        restart();
        seen_armed = 1'b0;
        sw = 16'h8000;
        for (int i = 0; i <= 257; i++) begin
            sample(sw, t);
            seen_armed |= armed_o;
            sw = sw + 16'd255;
        end
        chk("ext_last_sample", 32'(sw - 16'd255), 32'h7FFF);
        chk("ext_never_armed", 32'(seen_armed), 32'd0);
        chk("ext_no_trig", 32'(n_trig - base), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fmc_adc_thres_trig.md
# fmc_adc_thres_trig

Per-channel internal threshold trigger for the FMC-ADC 100 Ms/s core. It sits between the gain/offset/saturation stage and the acquisition FSM's trigger OR-tree. It watches the corrected signed sample stream and applies hysteresis arming, a glitch filter and a programmable delay. For every qualified threshold crossing it emits a single-cycle trigger pulse. The CH1..CH4 TRIG_THRES CSR fields feed its threshold and hysteresis inputs directly.

## Interface
- g_DATA_WIDTH, 16, sample, threshold and hysteresis width
- g_GLITCH_WIDTH, 8, glitch-filter length counter width
- g_DLY_WIDTH, 32, trigger delay counter width
- clk_i  in  1  sampling-domain clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- en_i  in  1  channel trigger enable (TRIG_EN CHx bit)
- pol_i  in  1  0 = rising crossing, 1 = falling crossing
- thres_i  in  g_DATA_WIDTH  signed threshold value
- hyst_i  in  g_DATA_WIDTH  unsigned hysteresis
- glitch_len_i  in  g_GLITCH_WIDTH  extra consecutive crossing samples required
- dly_i  in  g_DLY_WIDTH  delay in sample strobes
- data_i  in  g_DATA_WIDTH  signed corrected sample
- data_valid_i  in  1  sample strobe
- trig_o  out  1  one-cycle trigger pulse
- armed_o  out  1  high in ARMED or QUALIFY
- busy_o  out  1  high in DELAY

## Operation
- Arithmetic uses g_DATA_WIDTH+1 signed values: lo = thres − hyst and hi = thres + hyst. There is no wrap and no saturation. Samples are sign-extended before comparison.
- Rising polarity (pol_i = 0):
  - arm condition: data < lo
  - cross condition: data ≥ thres
- Falling polarity (pol_i = 1):
  - arm condition: data > hi
  - cross condition: data ≤ thres
- States: IDLE, WAIT_ARM, ARMED, QUALIFY, DELAY. Transitions are evaluated only on data_valid_i, except en_i, which is checked every cycle.
- IDLE: go to WAIT_ARM when en_i = 1.
- WAIT_ARM: on an arm sample, go to ARMED.
- ARMED: on a cross sample:
  - glitch_len_i = 0: fire.
  - otherwise: go to QUALIFY with the counter at 1.
- QUALIFY: on a cross sample, increment the counter. Fire when the counter reaches glitch_len_i + 1 total crossing samples. On a non-cross sample, return to ARMED and clear the counter.
- Fire behaviour:
  - dly_i = 0: assert trig_o on the next cycle and go to WAIT_ARM.
  - dly_i ≠ 0: load the delay counter with dly_i and go to DELAY.
- DELAY: decrement on each data_valid_i. On reaching 0, pulse trig_o and go to WAIT_ARM. Crossings in DELAY are ignored; there is no retrigger or queueing.
- hyst_i = 0 is legal: arm when below thres, cross at thres.
- en_i = 0 in any state: go to IDLE on the next edge and clear both counters. A pending trigger in DELAY is discarded.
- thres_i, hyst_i, pol_i, glitch_len_i and dly_i must be stable while en_i = 1. Changing them while enabled gives undefined trigger behaviour, but the FSM must not lock up.

## Timing
- Reset values: trig_o = 0, armed_o = 0, busy_o = 0, state = IDLE, both counters 0.
- All outputs are registered.
- Latency with dly_i = 0: the qualifying strobe is at cycle k, and trig_o = 1 during cycle k+1 only.
- Latency with dly_i = N: trig_o pulses in the cycle after the N-th data_valid_i following the qualifying strobe.
- Minimum sample re-arm: after trig_o, at least one arm sample is needed before the next fire. A continuously high signal produces exactly one trigger.
- data_valid_i may be high every cycle or sparse. Gaps do not reset the glitch count.
- If reset is asserted mid-DELAY, outputs clear asynchronously and no pulse follows reset release.

## Structure
- Shared package fmc_adc_trig_pkg holds:
  - the state enum t_thres_trig_state;
  - constants c_POL_RISING = 0 and c_POL_FALLING = 1;
  - the comparison helper function f_cmp_cross (pol, data, thres).
- The package is also used by the external trigger path.
- One sub-module: fmc_adc_trig_dly, a loadable down-counter clocked by data_valid_i with a done pulse. The external-trigger delay reuses it.
- Four instances of the top module are placed in fmc_adc_100Ms_core, one per channel.

## Test plan
- Rising threshold: thres = 0x300, hyst = 0x100, glitch = 0, dly = 0; samples 0x100 then 0x310 → trig_o one cycle after the 0x310 strobe, exactly once. Holding 0x310 for 50 samples gives no further pulse.
- Hysteresis: same configuration; samples 0x100, 0x310, 0x250, 0x310 → one trigger only, because 0x250 is not below lo = 0x200. A following 0x1F0 then 0x310 → second trigger.
- Glitch filter: glitch = 2; samples 0x100, 0x310, 0x310, 0x200, 0x310, 0x310, 0x310 → no pulse on the first pair, pulse after the third consecutive 0x310.
- Falling polarity with delay: pol = 1, thres = 0, hyst = 0x40, dly = 3; samples 0x50 then −0x10 → trig_o after the third subsequent strobe. A second crossing inside DELAY is ignored and busy_o stays high for those strobes.
- Disable/reset mid-delay: dly = 100; deassert en_i after 10 strobes → no trig_o, state returns to IDLE, busy_o = 0. Repeat with rst_n_i low → all outputs 0 immediately.
- Extremes: thres = −0x8000, hyst = 0x7FFF, rising → lo = −0xFFFF with no wrap, so the channel never arms and no trigger is produced for full-scale sweeps.
